// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the parallel-in/serial-out shift register.
// Holds the FSM state encoding, the beat-count helper and bit-order constants.
package shift_reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam bit ORD_MSB_FIRST = 1'b1;
    localparam bit ORD_LSB_FIRST = 1'b0;

    function automatic int beats(input int width, input int lane);
        return width / lane;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register: WIDTH-bit word out LANE bits per beat.
// Optional SHIFT_REG_ROTATE_EN: refill vacated lanes with the emitted lane.
module piso_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int LANE      = 1,
    parameter bit MSB_FIRST = ORD_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [LANE-1:0]  sin,
    input  logic             shift_en,
    output logic [LANE-1:0]  sout,
    output logic             sout_valid,
    output logic [WIDTH-1:0] par_out,
    output logic             busy,
    output logic             done
);

    localparam int BEATS = beats(WIDTH, LANE);
    localparam int CW    = $clog2(BEATS + 1);

    if ((LANE < 1) || (WIDTH % LANE != 0) || (WIDTH < 2 * LANE)) begin : g_bad_params
        $error("piso_shift_reg: WIDTH must be a multiple of LANE and >= 2*LANE");
    end

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [LANE-1:0]  fill;
    logic [WIDTH-1:0] shifted;
    logic             last;
    logic             take;

    if (MSB_FIRST) begin : g_msb
        assign sout    = shreg[WIDTH-1 -: LANE];
        assign shifted = {shreg[WIDTH-LANE-1:0], fill};
    end else begin : g_lsb
        assign sout    = shreg[LANE-1:0];
        assign shifted = {fill, shreg[WIDTH-1:LANE]};
    end

`ifdef SHIFT_REG_ROTATE_EN
    logic unused_sin;
    assign unused_sin = ^sin;
    assign fill       = sout;
`else
    assign fill = sin;
`endif

    // Last beat leaving this cycle frees the register for a gapless reload
    assign last       = (state == SHIFT) && (cnt == CW'(1)) && shift_en;
    assign load_ready = (state == IDLE) || last;
    assign take       = load_valid && load_ready;

    assign sout_valid = (state == SHIFT);
    assign busy       = (state == SHIFT);
    assign par_out    = shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= last;
            if (take) begin
                shreg <= load_data;
                cnt   <= CW'(BEATS);
                state <= SHIFT;
            end else if ((state == SHIFT) && shift_en) begin
                shreg <= shifted;
                cnt   <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Randomised and directed bench for piso_shift_reg against an arithmetic model.
// Three instances: 8/2 MSB-first, 8/2 LSB-first, 8/1 MSB-first.
module tb_piso_shift_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic       shift_en;
    logic [7:0] load_data;
    logic [1:0] sin2;
    logic       sin1;

    logic [2:0] lr, sv, bz, dn;
    logic [1:0] so0, so1;
    logic       so2;
    logic [7:0] po0, po1, po2;

    int errs   = 0;
    int checks = 0;

    int    wd [3] = '{8, 8, 8};
    int    ln [3] = '{2, 2, 1};
    int    msb[3] = '{1, 0, 1};
    int    pm [3] = '{0, 0, 0};
    int    rem[3] = '{0, 0, 0};
    int    dx [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    piso_shift_reg #(.WIDTH(8), .LANE(2), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
        .load_ready(lr[0]), .sin(sin2), .shift_en(shift_en), .sout(so0),
        .sout_valid(sv[0]), .par_out(po0), .busy(bz[0]), .done(dn[0])
    );

    piso_shift_reg #(.WIDTH(8), .LANE(2), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
        .load_ready(lr[1]), .sin(sin2), .shift_en(shift_en), .sout(so1),
        .sout_valid(sv[1]), .par_out(po1), .busy(bz[1]), .done(dn[1])
    );

    piso_shift_reg #(.WIDTH(8), .LANE(1), .MSB_FIRST(1)) dut_b (
        .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
        .load_ready(lr[2]), .sin(sin1), .shift_en(shift_en), .sout(so2),
        .sout_valid(sv[2]), .par_out(po2), .busy(bz[2]), .done(dn[2])
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] g_sout(input int i);
        case (i)
            0: return {6'd0, so0};
            1: return {6'd0, so1};
            default: return {7'd0, so2};
        endcase
    endfunction

    function automatic logic [7:0] g_par(input int i);
        case (i)
            0: return po0;
            1: return po1;
            default: return po2;
        endcase
    endfunction

    function automatic int e_sout(input int i);
        int md = 1 << wd[i];
        int lm = 1 << ln[i];
        if (msb[i] != 0) return pm[i] / (md / lm);
        return pm[i] % lm;
    endfunction

    // Word viewed as a number: shifting toward the emitting end is a multiply
    // or divide by 2^LANE, with the fill entering at the opposite end.
    task automatic mstep(input int i, input bit r, input bit lv, input int ld,
                         input bit se, input int s);
        int md = 1 << wd[i];
        int lm = 1 << ln[i];
        int fl;
        if (r) begin
            pm[i] = 0; rem[i] = 0; dx[i] = 0;
            return;
        end
        dx[i] = (rem[i] == 1 && se) ? 1 : 0;
        if (lv && (rem[i] == 0 || dx[i] == 1)) begin
            pm[i]  = ld;
            rem[i] = wd[i] / ln[i];
        end else if (rem[i] > 0 && se) begin
`ifdef SHIFT_REG_ROTATE_EN
            fl = e_sout(i);
`else
            fl = s;
`endif
            if (msb[i] != 0) pm[i] = (pm[i] * lm + fl) % md;
            else             pm[i] = pm[i] / lm + fl * (md / lm);
            rem[i]--;
        end
    endtask

    task automatic cyc(input bit r, input bit lv, input logic [7:0] ld,
                       input bit se, input logic [1:0] s2);
        rst = r; load_valid = lv; load_data = ld; shift_en = se;
        sin2 = s2; sin1 = s2[0];
        #1;
        if (!r) begin
            for (int i = 0; i < 3; i++)
                chk($sformatf("ready%0d", i), {7'd0, lr[i]},
                    (rem[i] == 0 || (rem[i] == 1 && se)) ? 8'd1 : 8'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            mstep(i, r, lv, ld, se, (i == 2) ? int'(s2[0]) : int'(s2));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("valid%0d", i), {7'd0, sv[i]}, (rem[i] > 0) ? 8'd1 : 8'd0);
            chk($sformatf("busy%0d", i),  {7'd0, bz[i]}, (rem[i] > 0) ? 8'd1 : 8'd0);
            chk($sformatf("done%0d", i),  {7'd0, dn[i]}, 8'(dx[i]));
            chk($sformatf("sout%0d", i),  g_sout(i), 8'(e_sout(i)));
            chk($sformatf("par%0d", i),   g_par(i), 8'(pm[i]));
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 10; k++) cyc(0, 0, 8'h00, 1, 2'd0);
    endtask

    initial begin
        int dcnt;
        logic [7:0] fword;
        logic [7:0] exp_b2b [8];
        logic [7:0] exp_msb [3];
        logic [7:0] exp_lsb [3];
        exp_b2b = '{8'd2, 8'd3, 8'd1, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2};
        exp_msb = '{8'd3, 8'd1, 8'd0};
        exp_lsb = '{8'd1, 8'd3, 8'd2};

        cyc(1, 0, 8'h00, 0, 2'd0);
        cyc(1, 0, 8'h00, 0, 2'd0);
        chk("rst_ready", {7'd0, lr[0]}, 8'd1);
        chk("rst_par", po0, 8'h00);

        // Bit order, both directions
        cyc(0, 1, 8'hB4, 1, 2'd0);
        chk("t1_b1", {6'd0, so0}, 8'd2);
        chk("t2_b1", {6'd0, so1}, 8'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 8'h00, 1, 2'd0);
            chk("t1_beat", {6'd0, so0}, exp_msb[k]);
            chk("t2_beat", {6'd0, so1}, exp_lsb[k]);
            chk("t1_nodone", {7'd0, dn[0]}, 8'd0);
        end
        cyc(0, 0, 8'h00, 1, 2'd0);
        chk("t1_done", {7'd0, dn[0]}, 8'd1);
        chk("t1_busy", {7'd0, bz[0]}, 8'd0);
        cyc(0, 0, 8'h00, 1, 2'd0);
        chk("t1_pulse", {7'd0, dn[0]}, 8'd0);
        drain();

        // Back-to-back words
        dcnt = 0;
        cyc(0, 1, 8'hB4, 1, 2'd0);
        chk("t3_beat", {6'd0, so0}, exp_b2b[0]);
        for (int k = 1; k < 8; k++) begin
            cyc(0, (k <= 4), 8'h5A, 1, 2'd0);
            dcnt += int'(dn[0]);
            chk("t3_beat", {6'd0, so0}, exp_b2b[k]);
            chk("t3_gap", {7'd0, sv[0]}, 8'd1);
        end
        cyc(0, 0, 8'h00, 1, 2'd0);
        dcnt += int'(dn[0]);
        chk("t3_dones", 8'(dcnt), 8'd2);
        drain();

        // Stalls
        dcnt = 0;
        cyc(0, 1, 8'hB4, 0, 2'd0);
        for (int k = 0; k < 14; k++) begin
            cyc(0, 0, 8'h00, (k % 3 == 0), 2'd0);
            dcnt += int'(dn[0]);
        end
        chk("t4_dones", 8'(dcnt), 8'd1);
        drain();

        // Reset mid-word
        cyc(0, 1, 8'hB4, 1, 2'd0);
        cyc(0, 0, 8'h00, 1, 2'd0);
        cyc(0, 0, 8'h00, 1, 2'd0);
        cyc(1, 0, 8'h00, 0, 2'd0);
        chk("t5_busy", {7'd0, bz[0]}, 8'd0);
        chk("t5_par", po0, 8'h00);
        chk("t5_ready", {7'd0, lr[0]}, 8'd1);
        chk("t5_done", {7'd0, dn[0]}, 8'd0);
        cyc(0, 1, 8'h3C, 1, 2'd0);
        chk("t5_reload", {6'd0, so0}, 8'd0);
        drain();

        // Fill / rotate
`ifdef SHIFT_REG_ROTATE_EN
        fword = 8'hB4;
`else
        fword = 8'h00;
`endif
        cyc(0, 1, fword, 1, 2'd3);
        for (int k = 0; k < 8; k++) cyc(0, 0, 8'h00, 1, 2'd3);
`ifdef SHIFT_REG_ROTATE_EN
        chk("t6_rot", po2, 8'hB4);
`else
        chk("t6_fill", po2, 8'hFF);
`endif
        drain();

        for (int k = 0; k < 600; k++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
                8'($urandom), ($urandom_range(0, 9) < 7), 2'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
